l2_dmem_bank_ctrl: RTL and testbench
====================================

Name: l2_dmem_bank_ctrl

Overview:
- Initiator-side controller for one 32 KB L2 data-memory bank: 1024 x 256-bit, single-port, active-high CE/WE, read data valid one cycle after a read strobe.
- Accepts valid/ready requests from the dNoC side and drives the bank's CE/WE/ADDR/WR_DATA.
- Captures RD_DATA into a response FIFO with backpressure.
- Supports per-32-bit-word write masks through a read-modify-write (RMW) sequence, because the bank has no write mask.

Parameters:
- ADDR_W, 10, bank word-address width.
- DATA_W, 256, bank data width; must be a multiple of 32.
- NWORD, DATA_W/32, number of 32-bit lanes (mask width).
- RSP_DEPTH, 2, read-response FIFO depth; must be >= 2.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  bank word address
- req_wdata  in  DATA_W  write data
- req_wmask  in  NWORD  per-lane write enable (bit i covers bits 32i+31:32i)
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer ready
- rsp_rdata  out  DATA_W  read data
- CE  out  1  bank chip enable
- WE  out  1  bank write enable
- ADDR  out  ADDR_W  bank address
- WR_DATA  out  DATA_W  bank write data
- RD_DATA  in  DATA_W  bank read data (valid in the cycle after CE && !WE)
- busy  out  1  RMW in progress, or a read is in flight, or the FIFO is non-empty

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-high, on RST.
- Reset:
  - Outputs: req_ready=0 during reset; rsp_valid=0, CE=0, WE=0, ADDR=0, WR_DATA=0, busy=0.
  - State: FSM goes to IDLE; FIFO is emptied; in-flight read flag is cleared. Data returning from a read issued before reset is discarded.
  - Reset mid-RMW: the pending merge write is dropped, so the bank is left unmodified.
- FSM has two states: IDLE and RMW_WR.
- Credit rule:
  - occ = FIFO occupancy + rd_inflight.
  - A read may be accepted only when occ < RSP_DEPTH, evaluated on registered state. A same-cycle FIFO pop does not free a credit.
- req_ready:
  - In IDLE: req_ready = !RST && (req_we || occ < RSP_DEPTH).
  - In RMW_WR: req_ready = 0.
- IDLE, accepted read: CE=1, WE=0, ADDR=req_addr (all combinational from the request); rd_inflight=1 next cycle.
- IDLE, accepted write with mask all-ones: CE=1, WE=1, ADDR=req_addr, WR_DATA=req_wdata. Single cycle, no response.
- IDLE, accepted write with mask all-zero: no bank access (CE=0), no response. Completes as a no-op.
- IDLE, accepted write with partial mask:
  - Same cycle: CE=1, WE=0, ADDR=req_addr.
  - Latch addr/wdata/wmask; do not set rd_inflight; go to RMW_WR.
- RMW_WR:
  - Drive CE=1, WE=1, ADDR=latched addr.
  - WR_DATA lane i = wmask[i] ? latched wdata lane i : RD_DATA lane i (RD_DATA is valid this cycle).
  - Return to IDLE next cycle. Total occupancy is 2 cycles.
- Read data return:
  - In the cycle where rd_inflight=1, RD_DATA is pushed into the FIFO at the clock edge.
  - Read accepted at cycle T: rsp_valid is first possible at T+2; no bypass.
  - Because of the credit rule, the push never overflows.
- Back-to-back reads: one per cycle while credits last.
- Ordering: responses are returned in request order. A read after an RMW to the same address returns the merged data, because RMW blocks acceptance until its write is issued.
- FIFO: rsp_valid = !empty; pop on rsp_valid && rsp_ready. Simultaneous push and pop in the same cycle keeps occupancy unchanged.
- Idle outputs: when no access is issued, CE=0 and WE=0. ADDR and WR_DATA are don't-care but are held at 0 for power/debug.
- Bank read latency is exactly 1 cycle; the controller never issues two accesses in one cycle.
- req_* signals need only be stable in the accept cycle; RMW uses latched copies.

Test Plan:
- Reset then idle -> CE=0, WE=0, rsp_valid=0, busy=0; req_ready=1 from the first cycle after RST falls.
- Full write addr 0x005 data lanes 0x11111111..0x88888888, then read 0x005 with rsp_ready=1 -> write takes 1 cycle; read accepted at T, rsp_valid at T+2 with identical data.
- Mem at 0x3FF preloaded all 0xA5A5A5A5; write mask 0x0F, data all 0x5A5A5A5A; then read 0x3FF:
  - req_ready=0 for one cycle after accept.
  - Read returns lanes 0-3 = 0x5A5A5A5A and lanes 4-7 = 0xA5A5A5A5.
- rsp_ready=0, issue 4 back-to-back reads -> only 2 accepted (req_ready drops); FIFO holds 2. Raise rsp_ready -> responses drain in order; remaining reads then accepted, and all 4 return in order.
- Write mask 0x00 -> accepted; CE stays 0 that cycle; memory unchanged on readback.
- Assert RST in the RMW_WR cycle -> CE=0 that cycle; target word unchanged on readback; FIFO empty, rsp_valid=0.

Source files
------------

// File: rtl/l2_dmem_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : l2_dmem_bank_ctrl
// Description : Initiator-side controller for one single-port L2 data-memory
//               bank (1024 x 256-bit, read data one cycle after the strobe).
//               Accepts valid/ready requests and drives CE/WE/ADDR/WR_DATA.
//               Returns read data through a small response FIFO. Partial
//               writes use a two-cycle read-modify-write because the bank
//               has no byte or word mask.
// Ports       : CLK, RST                 - clock, synchronous active-high reset
//               req_valid/req_ready      - request handshake
//               req_we/addr/wdata/wmask  - request payload (wmask per 32-bit lane)
//               rsp_valid/ready/rdata    - read response handshake
//               CE/WE/ADDR/WR_DATA       - bank strobes and write data
//               RD_DATA                  - bank read data
//               busy                     - RMW, read in flight or FIFO non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module l2_dmem_bank_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 256,
    parameter int NWORD     = DATA_W / 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [NWORD-1:0]  req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              CE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              busy
);

    localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(RSP_DEPTH - 1);
    localparam logic [c_CNT_W:0]   c_DEPTH    = (c_CNT_W + 1)'(RSP_DEPTH);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_RMW_WR = 1'b1;

    logic [0:0]        r_state;
    logic              r_rd_inflight;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [NWORD-1:0]  r_wmask;

    logic [DATA_W-1:0]  r_fifo [RSP_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_CNT_W:0]  w_occ;
    logic              w_credit;
    logic              w_accept;
    logic              w_rd_acc;
    logic              w_wr_full;
    logic              w_rmw_start;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_merge;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Credits count both stored responses and the read whose data is still
    // on RD_DATA, so a push can never find the FIFO full. A pop in the same
    // cycle deliberately does not release a credit.
    assign w_occ    = {1'b0, r_count} + (c_CNT_W + 1)'(r_rd_inflight);
    assign w_credit = (w_occ < c_DEPTH);

    assign req_ready   = !RST && (r_state == c_IDLE) && (req_we || w_credit);
    assign w_accept    = req_valid && req_ready;
    assign w_rd_acc    = w_accept && !req_we;
    assign w_wr_full   = w_accept && req_we && (&req_wmask);
    assign w_rmw_start = w_accept && req_we && !(&req_wmask) && (|req_wmask);

    // Lane merge for the write half of an RMW: RD_DATA carries the old word
    // in this cycle because the read strobe went out on the previous one.
    for (genvar i = 0; i < NWORD; i++) begin : g_lane
        assign w_merge[32*i +: 32] = r_wmask[i] ? r_wdata[32*i +: 32] : RD_DATA[32*i +: 32];
    end

    always_comb begin
        CE      = 1'b0;
        WE      = 1'b0;
        ADDR    = '0;
        WR_DATA = '0;
        if (!RST && (r_state == c_RMW_WR)) begin
            CE      = 1'b1;
            WE      = 1'b1;
            ADDR    = r_addr;
            WR_DATA = w_merge;
        end else if (w_rd_acc || w_rmw_start) begin
            CE   = 1'b1;
            ADDR = req_addr;
        end else if (w_wr_full) begin
            CE      = 1'b1;
            WE      = 1'b1;
            ADDR    = req_addr;
            WR_DATA = req_wdata;
        end
    end

    assign rsp_valid = !RST && (r_count != '0);
    assign rsp_rdata = r_fifo[r_rd_ptr];
    assign w_push    = r_rd_inflight;
    assign w_pop     = rsp_valid && rsp_ready;
    assign busy      = !RST && ((r_state == c_RMW_WR) || r_rd_inflight || (r_count != '0));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= c_IDLE;
            r_rd_inflight <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wmask       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_rd_inflight <= w_rd_acc;
            if (r_state == c_RMW_WR) begin
                r_state <= c_IDLE;
            end else if (w_rmw_start) begin
                r_state <= c_RMW_WR;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wmask <= req_wmask;
            end
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Response storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            r_fifo[r_wr_ptr] <= RD_DATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_dmem_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_dmem_bank_ctrl
// Description : Directed self-checking bench for l2_dmem_bank_ctrl with a
//               behavioural 1-cycle-latency single-port bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_dmem_bank_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 256;
    localparam int NWORD  = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [NWORD-1:0]  req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              CE;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic [DATA_W-1:0] RD_DATA;
    logic              busy;

    logic [DATA_W-1:0] bank [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    l2_dmem_bank_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NWORD(NWORD), .RSP_DEPTH(2)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .CE(CE), .WE(WE), .ADDR(ADDR), .WR_DATA(WR_DATA), .RD_DATA(RD_DATA),
        .busy(busy)
    );

    // Bank model: single port, read data registered one cycle after strobe.
    always @(posedge CLK) begin
        if (CE) begin
            if (WE) bank[ADDR] <= WR_DATA;
            else    RD_DATA    <= bank[ADDR];
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for acceptance, return at the next
    // negedge with req_valid dropped.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [NWORD-1:0] wmask);
        int w;
        w = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
        #1;
        while (!req_ready && w < 20) begin
            @(negedge CLK); #1; w++;
        end
        if (!req_ready) chk("issue_ready_timeout", req_ready, 1);
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
        int w;
        w = 0;
        rsp_ready = 1'b1;
        issue(1'b0, addr, '0, '0);
        #1;
        while (!rsp_valid && w < 5) begin
            @(negedge CLK); #1; w++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk(tag, rsp_rdata, exp);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d5;
        logic [DATA_W-1:0] merged;
        logic [DATA_W-1:0] pre [4];
        logic [DATA_W-1:0] c3;
        int nacc;
        int nrx;

        d5     = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                  32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        merged = {{4{32'hA5A5A5A5}}, {4{32'h5A5A5A5A}}};
        c3     = {8{32'hC3C3C3C3}};
        for (int k = 0; k < 4; k++) pre[k] = {8{32'hC0DE0000 | 32'(k)}};

        // ---------------- reset ----------------
        RST = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h001;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_ce", CE, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        req_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_ce", CE, 0);
        chk("post_rst_we", WE, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rsp_valid", rsp_valid, 0);

        // ---------------- full write then read ----------------
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h005; req_wdata = d5; req_wmask = 8'hFF;
        #1;
        chk("fw_ce", CE, 1);
        chk("fw_we", WE, 1);
        chk("fw_addr", ADDR, 10'h005);
        chk("fw_wr_data", WR_DATA, d5);
        @(posedge CLK); @(negedge CLK);
        req_valid = 1'b0;
        #1;
        chk("fw_done_ce", CE, 0);
        chk("fw_done_ready", req_ready, 1);
        chk("fw_done_busy", busy, 0);

        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h005; rsp_ready = 1'b1;
        #1;
        chk("rd_ce", CE, 1);
        chk("rd_we", WE, 0);
        chk("rd_addr", ADDR, 10'h005);
        @(posedge CLK); @(negedge CLK);
        req_valid = 1'b0;
        #1;
        chk("rd_t1_rsp_valid", rsp_valid, 0);
        chk("rd_t1_busy", busy, 1);
        @(negedge CLK); #1;
        chk("rd_t2_rsp_valid", rsp_valid, 1);
        chk("rd_t2_data", rsp_rdata, d5);
        @(negedge CLK); #1;
        chk("rd_t3_rsp_valid", rsp_valid, 0);
        chk("rd_t3_busy", busy, 0);

        // ---------------- partial write (RMW) ----------------
        issue(1'b1, 10'h3FF, {8{32'hA5A5A5A5}}, 8'hFF);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h3FF;
        req_wdata = {8{32'h5A5A5A5A}}; req_wmask = 8'h0F;
        #1;
        chk("rmw_rd_ce", CE, 1);
        chk("rmw_rd_we", WE, 0);
        chk("rmw_rd_addr", ADDR, 10'h3FF);
        @(posedge CLK); @(negedge CLK);
        req_valid = 1'b0;
        #1;
        chk("rmw_wr_ready", req_ready, 0);
        chk("rmw_wr_ce", CE, 1);
        chk("rmw_wr_we", WE, 1);
        chk("rmw_wr_addr", ADDR, 10'h3FF);
        chk("rmw_wr_data", WR_DATA, merged);
        chk("rmw_wr_busy", busy, 1);
        @(negedge CLK); #1;
        chk("rmw_done_ready", req_ready, 1);
        chk("rmw_done_ce", CE, 0);
        chk("rmw_bank", bank[10'h3FF], merged);
        read_chk("rmw_readback", 10'h3FF, merged);

        // ---------------- backpressure / credits ----------------
        for (int k = 0; k < 4; k++) issue(1'b1, 10'(32'h10 + k), pre[k], 8'hFF);
        rsp_ready = 1'b0; nacc = 0; nrx = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h010;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (cyc == 4) begin
                chk("bp_accepted_before_drain", nacc, 2);
                chk("bp_fifo_valid", rsp_valid, 1);
                chk("bp_ready_low", req_ready, 0);
                rsp_ready = 1'b1;
                #1;
                chk("bp_pop_no_same_cycle_credit", req_ready, 0);
            end
            if (rsp_valid && rsp_ready) begin
                if (nrx < 4) chk("bp_rsp_data", rsp_rdata, pre[nrx]);
                nrx++;
            end
            if (req_valid && req_ready) nacc++;
            @(posedge CLK); @(negedge CLK);
            req_valid = (nacc < 4);
            req_addr  = 10'(32'h10 + nacc);
            if (nrx >= 4) break;
        end
        req_valid = 1'b0;
        chk("bp_total_accepted", nacc, 4);
        chk("bp_total_responses", nrx, 4);

        // ---------------- zero mask write ----------------
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h005;
        req_wdata = {8{32'hFFFFFFFF}}; req_wmask = 8'h00;
        #1;
        chk("m0_ready", req_ready, 1);
        chk("m0_ce", CE, 0);
        @(posedge CLK); @(negedge CLK);
        req_valid = 1'b0;
        #1;
        chk("m0_busy", busy, 0);
        chk("m0_ready_after", req_ready, 1);
        read_chk("m0_readback", 10'h005, d5);

        // ---------------- reset during RMW write cycle ----------------
        issue(1'b1, 10'h020, c3, 8'hFF);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h020;
        req_wdata = '0; req_wmask = 8'h01;
        @(posedge CLK); @(negedge CLK);
        req_valid = 1'b0; RST = 1'b1;
        #1;
        chk("rstrmw_ce", CE, 0);
        chk("rstrmw_we", WE, 0);
        chk("rstrmw_busy", busy, 0);
        chk("rstrmw_rsp_valid", rsp_valid, 0);
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rstrmw_after_busy", busy, 0);
        chk("rstrmw_after_rsp_valid", rsp_valid, 0);
        chk("rstrmw_after_ready", req_ready, 1);
        chk("rstrmw_bank", bank[10'h020], c3);
        @(negedge CLK);
        read_chk("rstrmw_readback", 10'h020, c3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
